pwm_sample_sequencer: RTL and testbench

PWM_SAMPLE_SEQUENCER -- requirements
Module: pwm_sample_sequencer

---
 rtl/pwm_sample_sequencer.sv | 163 ++++++++++++++++
 tb/tb_pwm_sample_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_sample_sequencer.sv
// pwm_sample_sequencer: buffers upstream 8-bit samples in a small FIFO and
// releases one sample to the pwmaudio modulator every DIV clock cycles.
// An empty FIFO at a sample tick outputs midscale (0x80) and sets a sticky
// underrun flag. Optional feature macro: PWM_SEQ_UNDERRUN_CNT_EN adds an
// 8-bit saturating underrun event counter on o_underrun_cnt.
module pwm_sample_sequencer #(
  parameter int DIV       = 256,
  parameter int DEPTH     = 4,
  parameter int PRIME_LVL = 2
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_enable,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_ready,
  input  logic       i_clr_underrun,
  output logic [7:0] o_data,
  output logic       o_load,
  output logic       o_busy,
  output logic       o_underrun
`ifdef PWM_SEQ_UNDERRUN_CNT_EN
  ,
  output logic [7:0] o_underrun_cnt
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] PRIME_CNT = CW'(PRIME_LVL);
  localparam logic [15:0]   TICK_LAST = 16'(DIV - 1);
  localparam logic [7:0]    MIDSCALE  = 8'h80;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [15:0]   tick_cnt;

  logic empty;
  logic full;
  logic tick;
  logic push;
  logic pop;
  logic underrun_evt;
  logic flush;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign o_ready = (state != IDLE) && !full;
  assign o_busy  = (state == RUN);

  // Next-state decode plus the push/pop/underrun events; dropping enable
  // overrides every other event in the same cycle.
  always_comb begin
    state_next   = state;
    tick         = 1'b0;
    push         = 1'b0;
    pop          = 1'b0;
    underrun_evt = 1'b0;
    flush        = 1'b0;
    tick = (state == RUN) && (tick_cnt == TICK_LAST);
    push = i_valid && o_ready;
    case (state)
      IDLE:    if (i_enable) state_next = PRIME;
      PRIME:   if (count >= PRIME_CNT) state_next = RUN;
      RUN:     if (tick && empty) state_next = PRIME;
      default: state_next = IDLE;
    endcase
    pop          = tick && !empty;
    underrun_evt = tick && empty;
    if (!i_enable) begin
      state_next   = IDLE;
      push         = 1'b0;
      pop          = 1'b0;
      underrun_evt = 1'b0;
      flush        = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  // Sample storage; contents are only meaningful between the pointers.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_data;
  end

  // FIFO pointers and occupancy; a simultaneous push and pop keeps count.
  always_ff @(posedge i_clk) begin
    if (i_reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sample-period counter runs only while staying in RUN, so entry starts at 0.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tick_cnt <= '0;
    end else if (state == RUN && state_next == RUN) begin
      tick_cnt <= tick ? 16'd0 : tick_cnt + 16'd1;
    end else begin
      tick_cnt <= '0;
    end
  end

  // Output sample and load strobe; o_data moves only with o_load or on IDLE entry.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_data <= MIDSCALE;
      o_load <= 1'b0;
    end else begin
      o_load <= pop || underrun_evt;
      if (flush)             o_data <= MIDSCALE;
      else if (pop)          o_data <= mem[rd_ptr];
      else if (underrun_evt) o_data <= MIDSCALE;
    end
  end

  // Sticky underrun flag; a new underrun beats a simultaneous clear.
  always_ff @(posedge i_clk) begin
    if (i_reset)             o_underrun <= 1'b0;
    else if (underrun_evt)   o_underrun <= 1'b1;
    else if (i_clr_underrun) o_underrun <= 1'b0;
  end

`ifdef PWM_SEQ_UNDERRUN_CNT_EN
  // Saturating underrun event counter; an event beats a simultaneous clear.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_underrun_cnt <= '0;
    end else if (underrun_evt) begin
      if (o_underrun_cnt != 8'hFF) o_underrun_cnt <= o_underrun_cnt + 8'd1;
    end else if (i_clr_underrun) begin
      o_underrun_cnt <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_pwm_sample_sequencer.sv
// Directed testbench for pwm_sample_sequencer with DIV=8, DEPTH=4,
// PRIME_LVL=2. Optional macro PWM_SEQ_UNDERRUN_CNT_EN enables the
// underrun counter checks.
module tb_pwm_sample_sequencer;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       valid;
  logic [7:0] data;
  logic       ready;
  logic       clr_underrun;
  logic [7:0] out_data;
  logic       load;
  logic       busy;
  logic       underrun;
`ifdef PWM_SEQ_UNDERRUN_CNT_EN
  logic [7:0] underrun_cnt;
`endif

  int total;
  int bad;
  int n;

  pwm_sample_sequencer #(
    .DIV(8),
    .DEPTH(4),
    .PRIME_LVL(2)
  ) dut (
    .i_clk(clk),
    .i_reset(reset),
    .i_enable(enable),
    .i_valid(valid),
    .i_data(data),
    .o_ready(ready),
    .i_clr_underrun(clr_underrun),
    .o_data(out_data),
    .o_load(load),
    .o_busy(busy),
    .o_underrun(underrun)
`ifdef PWM_SEQ_UNDERRUN_CNT_EN
    ,
    .o_underrun_cnt(underrun_cnt)
`endif
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if it does not match.
  task automatic checkOutput(input string tag, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Step until o_load is seen; n is the number of edges taken, -1 on timeout.
  task automatic waitLoad(input int maxCycles, output int cycles);
    cycles = -1;
    for (int i = 1; i <= maxCycles; i++) begin
      step();
      if (load) begin
        cycles = i;
        return;
      end
    end
  endtask

  // Hold valid with a sample until the FIFO takes it; returns edges taken, -1 on timeout.
  task automatic applyStimulus(input logic [7:0] sample, input int maxCycles, output int cycles);
    logic accepted;
    valid  = 1'b1;
    data   = sample;
    cycles = -1;
    for (int i = 1; i <= maxCycles; i++) begin
      accepted = ready;
      step();
      if (accepted) begin
        cycles = i;
        return;
      end
    end
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    reset        = 1'b1;
    enable       = 1'b0;
    valid        = 1'b0;
    data         = 8'h00;
    clr_underrun = 1'b0;
    #1;
    step();
    step();
    reset = 1'b0;

    // Reset values
    checkOutput("rst_data", out_data, 8'h80);
    checkOutput("rst_load", load, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_underrun", underrun, 0);
    checkOutput("rst_ready", ready, 0);
`ifdef PWM_SEQ_UNDERRUN_CNT_EN
    checkOutput("rst_ucnt", underrun_cnt, 0);
`endif

    // Enabled with no data: sits in PRIME
    enable = 1'b1;
    step();
    for (int i = 0; i < 12; i++) begin
      checkOutput("prime_ready", ready, 1);
      checkOutput("prime_busy", busy, 0);
      checkOutput("prime_load", load, 0);
      checkOutput("prime_data", out_data, 8'h80);
      step();
    end

    // Three samples, played every 8 cycles then underrun
    applyStimulus(8'h10, 4, n);
    checkOutput("p10_acc", n, 1);
    applyStimulus(8'h20, 4, n);
    applyStimulus(8'h30, 4, n);
    valid = 1'b0;
    checkOutput("run_busy", busy, 1);
    waitLoad(20, n);
    checkOutput("load1_gap", n, 8);
    checkOutput("load1_data", out_data, 8'h10);
    step();
    checkOutput("load1_pulse", load, 0);
    checkOutput("load1_hold", out_data, 8'h10);
    waitLoad(20, n);
    checkOutput("load2_gap", n, 7);
    checkOutput("load2_data", out_data, 8'h20);
    waitLoad(20, n);
    checkOutput("load3_gap", n, 8);
    checkOutput("load3_data", out_data, 8'h30);
    checkOutput("load3_underrun", underrun, 0);
    waitLoad(20, n);
    checkOutput("urun_gap", n, 8);
    checkOutput("urun_data", out_data, 8'h80);
    checkOutput("urun_flag", underrun, 1);
    checkOutput("urun_busy", busy, 0);
    checkOutput("urun_ready", ready, 1);

    // Plain clear of the sticky flag
    clr_underrun = 1'b1;
    step();
    clr_underrun = 1'b0;
    checkOutput("clr_flag", underrun, 0);
`ifdef PWM_SEQ_UNDERRUN_CNT_EN
    checkOutput("clr_ucnt", underrun_cnt, 0);
`endif

    // Clear coinciding with an underrun tick: set wins
    applyStimulus(8'h41, 4, n);
    applyStimulus(8'h42, 4, n);
    valid = 1'b0;
    waitLoad(20, n);
    checkOutput("c41_gap", n, 9);
    checkOutput("c41_data", out_data, 8'h41);
    waitLoad(20, n);
    checkOutput("c42_data", out_data, 8'h42);
    repeat (7) step();
    clr_underrun = 1'b1;
    step();
    clr_underrun = 1'b0;
    checkOutput("coll_load", load, 1);
    checkOutput("coll_data", out_data, 8'h80);
    checkOutput("coll_flag", underrun, 1);
`ifdef PWM_SEQ_UNDERRUN_CNT_EN
    checkOutput("coll_ucnt", underrun_cnt, 1);
`endif

    // Five back-to-back samples: FIFO fills, fifth waits for a pop
    applyStimulus(8'h51, 4, n);
    applyStimulus(8'h52, 4, n);
    applyStimulus(8'h53, 4, n);
    applyStimulus(8'h54, 4, n);
    checkOutput("full_ready", ready, 0);
    applyStimulus(8'h55, 20, n);
    valid = 1'b0;
    checkOutput("p55_wait", n, 8);
    checkOutput("f51_data", out_data, 8'h51);
    waitLoad(20, n);
    checkOutput("f52_gap", n, 7);
    checkOutput("f52_data", out_data, 8'h52);
    waitLoad(20, n);
    checkOutput("f53_data", out_data, 8'h53);
    waitLoad(20, n);
    checkOutput("f54_data", out_data, 8'h54);
    waitLoad(20, n);
    checkOutput("f55_data", out_data, 8'h55);
    waitLoad(20, n);
    checkOutput("f_urun_data", out_data, 8'h80);
    checkOutput("f_urun_busy", busy, 0);

    // Drop enable mid-RUN with three samples still queued
    applyStimulus(8'h61, 4, n);
    applyStimulus(8'h62, 4, n);
    applyStimulus(8'h63, 4, n);
    applyStimulus(8'h64, 4, n);
    valid = 1'b0;
    waitLoad(20, n);
    checkOutput("e61_gap", n, 7);
    checkOutput("e61_data", out_data, 8'h61);
    enable = 1'b0;
    step();
    checkOutput("dis_data", out_data, 8'h80);
    checkOutput("dis_busy", busy, 0);
    checkOutput("dis_ready", ready, 0);
    checkOutput("dis_load", load, 0);
    enable = 1'b1;
    step();
    checkOutput("reen_ready", ready, 1);
    repeat (10) step();
    checkOutput("flushed_busy", busy, 0);

    // Reset mid-RUN while a push is offered
    applyStimulus(8'h71, 4, n);
    applyStimulus(8'h72, 4, n);
    valid = 1'b0;
    step();
    step();
    checkOutput("pre_rst_busy", busy, 1);
    checkOutput("pre_rst_flag", underrun, 1);
    valid = 1'b1;
    data  = 8'h73;
    reset = 1'b1;
    step();
    reset = 1'b0;
    valid = 1'b0;
    checkOutput("mr_data", out_data, 8'h80);
    checkOutput("mr_load", load, 0);
    checkOutput("mr_busy", busy, 0);
    checkOutput("mr_flag", underrun, 0);
    checkOutput("mr_ready", ready, 0);
`ifdef PWM_SEQ_UNDERRUN_CNT_EN
    checkOutput("mr_ucnt", underrun_cnt, 0);
`endif
    step();
    checkOutput("mr_prime_ready", ready, 1);
    repeat (10) step();
    checkOutput("mr_empty_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
